// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sequencer and arbiter for the single byte-wide RAM port. Instruction fetch
// and the load/store buffer (LSB) share the port. One transaction runs at a
// time and moves 1, 2 or 4 consecutive bytes. Read bytes are assembled
// little-endian and returned with a one-cycle done pulse.
//
// Speculative work (fetch, load) is dropped on a ROB flush. A committed store
// always runs to completion. Only reset can cut a store short.
//
// Optional feature (macro MEMCTRL_RR_EN):
//   defined     : round-robin between fetch and LSB when both are pending.
//                 The last-granted flag resets to "fetch", so the LSB wins the
//                 first tie.
//   not defined : fixed priority, LSB over fetch.
//
// Ports
//   clk_in              system clock
//   rst_in              synchronous reset, active-low
//   rdy_in              global enable; low freezes every register and gates
//                       mem_wr to 0
//   rob_en_in           ROB flush/redirect; aborts FETCH/LOAD, blocks grants
//   io_buffer_full_in   UART output buffer full; stalls stores to the I/O
//                       window (addr[17:16] == 2'b11)
//   ifetch_en_in        fetch request
//   ifetch_pc_in        fetch address (always 4 bytes)
//   ifetch_rdy_out      arbiter idle, so a request is accepted this cycle
//   ifetch_en_out       one-cycle pulse: ifetch_inst_out is valid
//   ifetch_inst_out     fetched instruction; holds until the next pulse
//   lsb_en_in           LSB request
//   lsb_wr_in           1 = store, 0 = load
//   lsb_len_in          0 = 1 B, 1 = 2 B, 2 = 4 B (3 is treated as 4 B)
//   lsb_addr_in         byte address
//   lsb_data_in         store data; the low bytes are used
//   lsb_rdy_out         arbiter idle
//   lsb_en_out          one-cycle pulse: load data valid, or store done
//   lsb_data_out        zero-extended load data; holds until the next pulse
//   mem_din             RAM read data, valid for the address driven last cycle
//   mem_dout            RAM write data
//   mem_a               RAM address
//   mem_wr              RAM write strobe
// -----------------------------------------------------------------------------
module mem_arbiter (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_en_in,
   input  logic        io_buffer_full_in,
   input  logic        ifetch_en_in,
   input  logic [31:0] ifetch_pc_in,
   output logic        ifetch_rdy_out,
   output logic        ifetch_en_out,
   output logic [31:0] ifetch_inst_out,
   input  logic        lsb_en_in,
   input  logic        lsb_wr_in,
   input  logic [1:0]  lsb_len_in,
   input  logic [31:0] lsb_addr_in,
   input  logic [31:0] lsb_data_in,
   output logic        lsb_rdy_out,
   output logic        lsb_en_out,
   output logic [31:0] lsb_data_out,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_STORE = 2'd3;

   // Transaction registers. last_q holds N-1 (index of the final byte) and
   // idx_q the index of the byte whose address is on mem_a right now.
   logic [1:0]  state_q,       state_d;
   logic [31:0] base_q,        base_d;
   logic [1:0]  last_q,        last_d;
   logic [1:0]  idx_q,         idx_d;
   logic [31:0] asm_q,         asm_d;

   // Registered outputs.
   logic [31:0] mem_a_q,       mem_a_d;
   logic [7:0]  mem_dout_q,    mem_dout_d;
   logic        mem_wr_q,      mem_wr_d;
   logic        ifetch_en_q,   ifetch_en_d;
   logic [31:0] ifetch_inst_q, ifetch_inst_d;
   logic        lsb_en_q,      lsb_en_d;
   logic [31:0] lsb_data_q,    lsb_data_d;

`ifdef MEMCTRL_RR_EN
   // 1 when the most recent grant went to fetch.
   logic        last_fetch_q,  last_fetch_d;
`endif

   logic        lsb_req;
   logic        fetch_req;
   logic        grant_lsb;
   logic        grant_fetch;
   logic [1:0]  idx_next;
   logic [31:0] asm_rd;

   // Byte count encoded as the index of the last byte.
   function automatic logic [1:0] len_to_last(input logic [1:0] len);
      case (len)
         2'd0:    len_to_last = 2'd0;
         2'd1:    len_to_last = 2'd1;
         default: len_to_last = 2'd3;
      endcase
   endfunction

   // --------------------------------------------------------------------------
   // Request qualification and arbitration
   // --------------------------------------------------------------------------
   always_comb begin : arbitration
      // A store into the I/O window cannot start while the UART buffer is
      // full. It is then not pending at all, so fetch can take the slot.
      lsb_req   = lsb_en_in &&
                  !(lsb_wr_in && (lsb_addr_in[17:16] == 2'b11) && io_buffer_full_in);
      fetch_req = ifetch_en_in;
`ifdef MEMCTRL_RR_EN
      if (lsb_req && fetch_req) begin
         grant_lsb = last_fetch_q;
      end else begin
         grant_lsb = lsb_req;
      end
`else
      grant_lsb = lsb_req;
`endif
      grant_fetch = fetch_req && !grant_lsb;
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin : next_state
      // NOTE: every signal assigned in this block gets a default first, so no
      // path leaves a value unassigned and no latch is inferred.
      state_d       = state_q;
      base_d        = base_q;
      last_d        = last_q;
      idx_d         = idx_q;
      asm_d         = asm_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      mem_wr_d      = mem_wr_q;
      ifetch_en_d   = 1'b0;
      ifetch_inst_d = ifetch_inst_q;
      lsb_en_d      = 1'b0;
      lsb_data_d    = lsb_data_q;
`ifdef MEMCTRL_RR_EN
      last_fetch_d  = last_fetch_q;
`endif

      idx_next = idx_q + 2'd1;

      // Assembly register with the byte on mem_din merged in at its lane.
      asm_rd = asm_q;
      asm_rd[{idx_q, 3'b000} +: 8] = mem_din;

      case (state_q)
         ST_IDLE: begin
            // A flush cycle grants nothing, whoever is asking.
            if (!rob_en_in) begin
               if (grant_lsb) begin
                  base_d  = lsb_addr_in;
                  last_d  = len_to_last(lsb_len_in);
                  idx_d   = 2'd0;
                  mem_a_d = lsb_addr_in;
`ifdef MEMCTRL_RR_EN
                  last_fetch_d = 1'b0;
`endif
                  if (lsb_wr_in) begin
                     // The store data is captured here, because the request
                     // inputs are don't-care after the grant edge.
                     state_d    = ST_STORE;
                     asm_d      = lsb_data_in;
                     mem_dout_d = lsb_data_in[7:0];
                     mem_wr_d   = 1'b1;
                  end else begin
                     state_d = ST_LOAD;
                     asm_d   = '0;
                  end
               end else if (grant_fetch) begin
                  state_d = ST_FETCH;
                  base_d  = ifetch_pc_in;
                  last_d  = 2'd3;
                  idx_d   = 2'd0;
                  mem_a_d = ifetch_pc_in;
                  asm_d   = '0;
`ifdef MEMCTRL_RR_EN
                  last_fetch_d = 1'b1;
`endif
               end
            end
         end

         ST_FETCH, ST_LOAD: begin
            if (rob_en_in) begin
               // Speculative read is dropped: no done pulse, and the data
               // outputs keep their previous value.
               state_d = ST_IDLE;
            end else if (idx_q == last_q) begin
               state_d = ST_IDLE;
               if (state_q == ST_FETCH) begin
                  ifetch_en_d   = 1'b1;
                  ifetch_inst_d = asm_rd;
               end else begin
                  lsb_en_d   = 1'b1;
                  lsb_data_d = asm_rd;
               end
            end else begin
               asm_d   = asm_rd;
               idx_d   = idx_next;
               mem_a_d = base_q + {30'd0, idx_next};
            end
         end

         ST_STORE: begin
            // A committed store ignores the flush.
            if (idx_q == last_q) begin
               state_d  = ST_IDLE;
               mem_wr_d = 1'b0;
               lsb_en_d = 1'b1;
            end else begin
               idx_d      = idx_next;
               mem_a_d    = base_q + {30'd0, idx_next};
               mem_dout_d = asm_q[{idx_next, 3'b000} +: 8];
            end
         end

         default: begin
            state_d  = ST_IDLE;
            mem_wr_d = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q       <= ST_IDLE;
         base_q        <= '0;
         last_q        <= '0;
         idx_q         <= '0;
         asm_q         <= '0;
         mem_a_q       <= '0;
         mem_dout_q    <= '0;
         mem_wr_q      <= 1'b0;
         ifetch_en_q   <= 1'b0;
         ifetch_inst_q <= '0;
         lsb_en_q      <= 1'b0;
         lsb_data_q    <= '0;
`ifdef MEMCTRL_RR_EN
         last_fetch_q  <= 1'b1;
`endif
      end else if (rdy_in) begin
         state_q       <= state_d;
         base_q        <= base_d;
         last_q        <= last_d;
         idx_q         <= idx_d;
         asm_q         <= asm_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         mem_wr_q      <= mem_wr_d;
         ifetch_en_q   <= ifetch_en_d;
         ifetch_inst_q <= ifetch_inst_d;
         lsb_en_q      <= lsb_en_d;
         lsb_data_q    <= lsb_data_d;
`ifdef MEMCTRL_RR_EN
         last_fetch_q  <= last_fetch_d;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign ifetch_rdy_out  = (state_q == ST_IDLE);
   assign lsb_rdy_out     = (state_q == ST_IDLE);
   assign ifetch_en_out   = ifetch_en_q;
   assign ifetch_inst_out = ifetch_inst_q;
   assign lsb_en_out      = lsb_en_q;
   assign lsb_data_out    = lsb_data_q;
   assign mem_a           = mem_a_q;
   assign mem_dout        = mem_dout_q;
   // A frozen core must never write, even mid-store.
   assign mem_wr          = mem_wr_q & rdy_in;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM port, shared between instruction fetch and the load/store buffer. It accepts one transaction at a time and drives the 8-bit RAM interface for 1, 2 or 4 consecutive bytes. Read bytes are assembled little-endian and returned to the requester with a one-cycle done pulse. Speculative fetches and loads are dropped on a ROB flush; committed stores always run to completion.

## Interface
- No parameters.
- `clk_in` in 1 — system clock.
- `rst_in` in 1 — reset, synchronous, active-low.
- `rdy_in` in 1 — global enable; low freezes all state.
- `rob_en_in` in 1 — ROB flush/redirect this cycle.
- `io_buffer_full_in` in 1 — UART output buffer full.
- `ifetch_en_in` in 1 — fetch request.
- `ifetch_pc_in` in 32 — fetch address.
- `ifetch_rdy_out` out 1 — arbiter idle; a request is accepted this cycle.
- `ifetch_en_out` out 1 — one-cycle pulse: instruction valid.
- `ifetch_inst_out` out 32 — fetched instruction.
- `lsb_en_in` in 1 — LSB request.
- `lsb_wr_in` in 1 — 1 = store, 0 = load.
- `lsb_len_in` in 2 — 0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is illegal.
- `lsb_addr_in` in 32 — byte address.
- `lsb_data_in` in 32 — store data, low bytes used.
- `lsb_rdy_out` out 1 — arbiter idle.
- `lsb_en_out` out 1 — one-cycle pulse: load data valid, or store done.
- `lsb_data_out` out 32 — load data, zero-extended.
- `mem_din` in 8 — RAM read data.
- `mem_dout` out 8 — RAM write data.
- `mem_a` out 32 — RAM address.
- `mem_wr` out 1 — RAM write strobe.

## Operation
- **States:** IDLE, FETCH, LOAD, STORE. Registers: base address, byte count N (1/2/4), byte index k, assembly register.
- **Outputs from IDLE:** `ifetch_rdy_out` = `lsb_rdy_out` = (state == IDLE). Both requesters observe this signal.
- **Grant (IDLE, `rdy_in` = 1, `rob_en_in` = 0):**
  - If the LSB and fetch both request, the LSB wins. Round-robin applies only under the configuration macro.
  - A store with `lsb_addr_in[17:16]` == 2'b11 while `io_buffer_full_in` = 1 is not granted; fetch may be granted instead in that cycle.
  - Fetch always uses N = 4.
  - Request inputs are sampled only at the grant edge; they are don't-care afterwards.
- **Read (FETCH/LOAD):**
  - Byte k is requested at address base+k.
  - `mem_din` carries the byte one cycle after its address is driven.
  - Byte k is stored in bits [8k+7:8k]; upper bytes are 0.
- **Write (STORE):**
  - `mem_wr` = 1, `mem_a` = base+k, `mem_dout` = `lsb_data_in` byte k.
  - `mem_wr` = 0 once all N bytes are written.
- **Address arithmetic:** base+k is 32-bit and wraps modulo 2^32.
- **Flush:** `rob_en_in` = 1 at an edge in FETCH or LOAD aborts the transaction.
  - Return to IDLE, no done pulse, `mem_wr` = 0.
  - STORE ignores `rob_en_in` and completes normally.
  - Requests presented in a flush cycle are not granted.
- **Freeze:** `rdy_in` = 0 holds all registers. `mem_wr` is gated to 0 combinationally while `rdy_in` = 0.
- **Reset (`rst_in` = 0 at an edge), regardless of state:**
  - State → IDLE.
  - `mem_a`, `mem_dout`, `ifetch_inst_out` and `lsb_data_out` → 0.
  - `mem_wr`, `ifetch_en_out` and `lsb_en_out` → 0.
  - Any transaction in progress is discarded, including a store.

## Timing
- Grant edge E0: drive `mem_a` = base (plus `mem_dout`/`mem_wr` for a store).
- Edges E1..E(N−1): drive base+k. For reads, capture byte k−1 at edge Ek.
- Edge EN:
  - Read: capture byte N−1, assert the done pulse with the assembled data, and go to IDLE.
  - Store: deassert `mem_wr`, assert `lsb_en_out`, and go to IDLE.
- Done pulse is visible for exactly one cycle, after edge EN.
- Read latency is N+1 edges from grant to done visible. A store occupies N cycles of writes.
- The earliest next grant is edge EN+1, so back-to-back 4-byte fetches take 5 cycles each.
- Data outputs hold their last value until the next done pulse.

## Configuration
- **`MEMCTRL_RR_EN` defined:** round-robin arbitration.
  - When both requesters are pending, the one not granted last wins.
  - The last-granted flag resets to "fetch", so the LSB wins the first tie.
- **`MEMCTRL_RR_EN` not defined:** fixed priority, LSB over fetch.

## Test plan
- **Fetch:** pc 0x1000, RAM bytes 13 05 00 00. Expect `mem_a` 0x1000..0x1003 on consecutive cycles, `ifetch_en_out` pulse 5 cycles after grant, inst 0x00000513.
- **Load 2 B:** addr 0x2001, RAM 0x34 0x12. Expect `lsb_data_out` 0x00001234 with the `lsb_en_out` pulse after 3 edges.
- **Store 4 B with flush:** 0x11223344 to 0x3000, `rob_en_in` pulsed at cycle 1. Expect `mem_wr` high 4 cycles with bytes 44 33 22 11, then `lsb_en_out`; no abort.
- **Fetch with flush:** fetch in progress, `rob_en_in` at cycle 2. Expect no `ifetch_en_out`, `mem_wr` stays 0, IDLE at the next cycle.
- **Simultaneous requests:** fetch and load issued together twice in a row. Without the macro the LSB wins both; with `MEMCTRL_RR_EN` the first tie goes to the LSB and the second to fetch.
- **IO stall:** store 1 B to 0x30000 with `io_buffer_full_in` = 1 and a pending fetch. Expect the fetch to be granted and the store to be granted only after full drops.
- **Mid-operation reset:** `rdy_in` low mid-load holds `mem_a` unchanged. Reset mid-store gives `mem_wr` = 0 and all outputs 0 on the next cycle.
